uart_rx_ctrl: RTL

Sequencing controller for the UART receive path. It synchronises the raw uart_rx line and detects and qualifies the start bit. It times mid-bit sampling from an internal per-bit clock counter and checks the stop bit. Accepted bytes go into a small first-word-fall-through FIFO with a valid/ready handshake toward the consumer, and the block flags framing and overrun errors.

---
 rtl/uart_rx_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: line synchroniser, start/data/stop sequencing and a
// first-word-fall-through byte FIFO with framing and overrun flags.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 20,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count
);
  // state | meaning
  // IDLE  | line idle, waiting for a low level
  // START | timing to mid start bit to qualify it
  // DATA  | sampling 8 data bits, LSB first
  // STOP  | sampling stop bit, push byte or flag framing error
  // BREAK | line still low after a bad stop bit, wait for release
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0]    HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]    BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(FIFO_DEPTH);

  logic          sync1, rxs;
  state_t        state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          push_req, ferr_set;
  logic          pop, push_ok;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + TW'(1);
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    push_req    = 1'b0;
    ferr_set    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rxs) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rxs, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        // leaving at mid stop bit lets a back-to-back start edge be seen
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          push_req  = rxs;
          ferr_set  = ~rxs;
          state_nxt = rxs ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (rxs) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy     = (state != IDLE);
  assign rx_valid = (fifo_count != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
  assign pop      = rx_valid & rx_ready;
  // a full FIFO still takes the byte when the head leaves on the same edge
  assign push_ok  = push_req & ((fifo_count < DEPTH) | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= push_req & ~push_ok;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok & ~pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (pop & ~push_ok) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

endmodule
